// File: rtl/alu_mc.sv
// alu_mc: registered, handshaked ALU with an iterative shift-and-add multiplier.
//
// Sits between register-file read and writeback. An operation transfers on a
// rising clk edge when in_valid && in_ready. Single-cycle ops produce a
// registered result with out_valid pulsing the following cycle, so back-to-back
// issue is possible every cycle. MUL (when MUL_EN=1) takes WIDTH busy cycles
// during which in_ready is low.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands and op presented this cycle
//   in_ready   block can accept an operation (high only in IDLE)
//   a, b       WIDTH-bit operands
//   alu_op     000 AND, 001 OR, 010 ADD, 011 XOR, 100 MUL, 101 NOR, 110 SUB, 111 SLT
//   out_valid  one-cycle pulse: result/flags belong to a newly finished op
//   result     registered result, held between pulses
//   zero       result == 0
//   n          sign class of result: 01 zero, 10 negative, 11 positive
//   overflow   signed overflow of the last ADD/SUB, 0 for other ops
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [1:0]       n,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] aluRes;
  logic             aluOvf;
  logic [WIDTH-1:0] mulStep;
  logic             isMul;
  logic             accept;

  assign sum     = a + b;
  assign diff    = a - b;
  assign mulStep = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign isMul   = (MUL_EN != 1'b0) && (alu_op == 3'b100);
  assign in_ready = (state_q == IDLE);
  assign accept  = in_valid && in_ready;

  // Single-cycle datapath. Op 100 lands here only when the multiplier is
  // disabled, in which case it behaves as AND.
  always_comb begin
    aluRes = '0;
    aluOvf = 1'b0;
    case (alu_op)
      3'b000: aluRes = a & b;
      3'b001: aluRes = a | b;
      3'b010: begin
        aluRes = sum;
        aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b011: aluRes = a ^ b;
      3'b100: aluRes = a & b;
      3'b101: aluRes = ~(a | b);
      3'b110: begin
        aluRes = diff;
        aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
    endcase
  end

  // Next-state logic. The multiplier retires on the busy edge where cnt_q is
  // WIDTH-1, folding that last partial product straight into the result.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    outValid_d = 1'b0;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (isMul) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL_BUSY;
          end else begin
            result_d   = aluRes;
            ovf_d      = aluOvf;
            outValid_d = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        acc_d    = mulStep;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d   = mulStep;
          ovf_d      = 1'b0;
          outValid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Flags are decoded from the registered result so they hold with it.
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign out_valid = outValid_q;
  assign zero      = (result_q == '0);
  assign n         = zero ? 2'b01 : (result_q[WIDTH-1] ? 2'b10 : 2'b11);

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc with a 32-bit and an 8-bit instance.
// Expected results come from a behavioural model and are queued at issue time;
// a negedge monitor pops and compares them when out_valid pulses, including the
// cycle in which the pulse is expected.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        v32, v8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        rdy32, rdy8, ov32, ov8, z32, z8, of32, of8;
  logic [1:0]  n32, n8;
  logic [31:0] res32;
  logic [7:0]  res8;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int   tests = 0;
  int   failures = 0;
  int   cyc = 0;
  int   readyAt32 = 0;
  int   readyAt8 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32),
    .a(a32), .b(b32), .alu_op(op32), .out_valid(ov32), .result(res32),
    .zero(z32), .n(n32), .overflow(of32)
  );

  alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .alu_op(op8), .out_valid(ov8), .result(res8),
    .zero(z8), .n(n8), .overflow(of8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {overflow, result} for a w-bit ALU.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [63:0] ai,
                                        input logic [63:0] bi, input int w);
    logic [63:0] mask, a, b, r;
    logic        ovf;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    a = ai & mask;
    b = bi & mask;
    r = '0;
    ovf = 1'b0;
    sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
    sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        r = (a + b) & mask;
        ovf = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'b011: r = a ^ b;
      3'b100: r = (a * b) & mask;
      3'b101: r = ~(a | b) & mask;
      3'b110: begin
        r = (a - b) & mask;
        ovf = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      default: r = (sa < sb) ? 64'd1 : 64'd0;
    endcase
    return {ovf, r};
  endfunction

  task automatic checkResult(input string tag, input int w, input logic [63:0] res,
                             input logic z, input logic [1:0] nn, input logic ovf,
                             input exp_t e);
    logic       expZ;
    logic [1:0] expN;
    expZ = (e.res == 64'd0);
    expN = expZ ? 2'b01 : (e.res[w-1] ? 2'b10 : 2'b11);
    checkOutput({tag, " result"}, res, e.res);
    checkOutput({tag, " zero"}, z, expZ);
    checkOutput({tag, " n"}, nn, expN);
    checkOutput({tag, " overflow"}, ovf, e.ovf);
    checkOutput({tag, " out_valid cycle"}, cyc, e.cyc);
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest queued op.
  always @(negedge clk) begin
    if (ov32 === 1'b1) begin
      if (q32.size() == 0) checkOutput("w32 unexpected out_valid", 64'd1, 64'd0);
      else begin
        e32 = q32.pop_front();
        checkResult("w32", 32, 64'(res32), z32, n32, of32, e32);
      end
    end
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) checkOutput("w8 unexpected out_valid", 64'd1, 64'd0);
      else begin
        e8 = q8.pop_front();
        checkResult("w8", 8, 64'(res8), z8, n8, of8, e8);
      end
    end
  end

  // Presents one op, holding in_valid through any busy period, and queues the
  // expected result with the cycle its out_valid pulse should appear.
  task automatic applyStimulus(input bit is8, input logic [2:0] op,
                               input logic [63:0] a, input logic [63:0] b);
    int          w;
    int          ready;
    int          guard;
    logic [64:0] m;
    exp_t        e;
    string       tag;
    w = is8 ? 8 : 32;
    tag = is8 ? "w8" : "w32";
    @(negedge clk);
    if (is8) begin
      v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      ready = readyAt8;
    end else begin
      v32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
      ready = readyAt32;
    end
    guard = 0;
    while (cyc < ready && guard < 200) begin
      checkOutput({tag, " busy in_ready"}, is8 ? rdy8 : rdy32, 64'd0);
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, " accept in_ready"}, is8 ? rdy8 : rdy32, 64'd1);
    m = model(op, a, b, w);
    e.res = m[63:0];
    e.ovf = m[64];
    e.cyc = cyc + 1 + ((op == 3'b100) ? w : 0);
    if (is8) begin
      q8.push_back(e);
      readyAt8 = e.cyc;
    end else begin
      q32.push_back(e);
      readyAt32 = e.cyc;
    end
    @(posedge clk);
    #1;
    if (is8) v8 = 1'b0;
    else v32 = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain pending w32", 64'(q32.size()), 64'd0);
    checkOutput("drain pending w8", 64'(q8.size()), 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " w32 in_ready"}, rdy32, 64'd1);
    checkOutput({tag, " w32 out_valid"}, ov32, 64'd0);
    checkOutput({tag, " w32 result"}, res32, 64'd0);
    checkOutput({tag, " w32 zero"}, z32, 64'd1);
    checkOutput({tag, " w32 n"}, n32, 64'd1);
    checkOutput({tag, " w32 overflow"}, of32, 64'd0);
    checkOutput({tag, " w8 in_ready"}, rdy8, 64'd1);
    checkOutput({tag, " w8 result"}, res8, 64'd0);
    checkOutput({tag, " w8 n"}, n8, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    v32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;
    readyAt32 = cyc;
    readyAt8 = cyc;

    // Logic ops, SUB/ADD edge cases, SLT, NOR, all issued back-to-back.
    applyStimulus(1'b0, 3'b000, 64'h0000000C, 64'h0000000A);
    applyStimulus(1'b0, 3'b001, 64'h0000000C, 64'h0000000A);
    applyStimulus(1'b0, 3'b011, 64'h0000000C, 64'h0000000A);
    applyStimulus(1'b0, 3'b110, 64'h0000000A, 64'h0000000C);
    applyStimulus(1'b0, 3'b110, 64'hFFFFFFFF, 64'hFFFFFFFF);
    applyStimulus(1'b0, 3'b010, 64'h7FFFFFFF, 64'h00000001);
    applyStimulus(1'b0, 3'b111, 64'hFFFFFFFF, 64'h00000001);
    applyStimulus(1'b0, 3'b111, 64'h00000001, 64'hFFFFFFFF);
    applyStimulus(1'b0, 3'b101, 64'h00000000, 64'h00000000);
    applyStimulus(1'b0, 3'b110, 64'h80000000, 64'h00000001);
    repeat (3) @(negedge clk);

    // Multiply, then an ADD held on in_valid throughout the busy period.
    applyStimulus(1'b0, 3'b100, 64'h0000000C, 64'h0000000A);
    applyStimulus(1'b0, 3'b010, 64'h00000005, 64'h00000003);
    applyStimulus(1'b0, 3'b100, 64'hDEADBEEF, 64'h12345678);

    // Narrow instance: wrapping multiplies and signed overflow.
    applyStimulus(1'b1, 3'b100, 64'h10, 64'h10);
    applyStimulus(1'b1, 3'b010, 64'h7F, 64'h01);
    applyStimulus(1'b1, 3'b110, 64'h80, 64'h01);
    applyStimulus(1'b1, 3'b100, 64'hFF, 64'hFF);
    applyStimulus(1'b1, 3'b111, 64'h80, 64'h7F);

    // Mixed random ops on the wide instance.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 3'($urandom_range(0, 7)), 64'($urandom), 64'($urandom));
    end
    drain();

    // Reset five cycles into a multiply: the op must vanish without a pulse.
    applyStimulus(1'b0, 3'b001, 64'h00000001, 64'h00000002);
    drain();
    @(negedge clk);
    v32 = 1'b1; op32 = 3'b100; a32 = 32'h0000000C; b32 = 32'h0000000A;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid-mul in_ready", rdy32, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    checkResetState("abort");
    reset = 1'b0;
    readyAt32 = cyc;
    readyAt8 = cyc;
    repeat (45) @(negedge clk);
    applyStimulus(1'b0, 3'b010, 64'h00000002, 64'h00000003);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
